// File: rtl/seg_pkg.sv
// Shared constants for the count/tally 7-segment display: segment table, digit enables,
// wrap detection values and a 3-digit BCD increment helper.
package seg_pkg;

  localparam logic [3:0] WRAP_FROM = 4'hF;
  localparam logic [3:0] WRAP_TO   = 4'h0;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  localparam logic [3:0] AN_PAT [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  // Returns {carry_out, hundreds, tens, units}; carry_out marks the 999 -> 000 rollover.
  function automatic logic [12:0] bcd3_inc(input logic [11:0] v);
    logic [3:0] u;
    logic [3:0] t;
    logic [3:0] h;
    logic       c;
    u = v[3:0];
    t = v[7:4];
    h = v[11:8];
    c = 1'b0;
    if (u == 4'd9) begin
      u = 4'd0;
      if (t == 4'd9) begin
        t = 4'd0;
        if (h == 4'd9) begin
          h = 4'd0;
          c = 1'b1;
        end else begin
          h = h + 4'd1;
        end
      end else begin
        t = t + 4'd1;
      end
    end else begin
      u = u + 4'd1;
    end
    return {c, h, t, u};
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex nibble to active-low 7-segment decoder.
module seg7_decode
  import seg_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_TABLE[digit_i];

endmodule

// File: rtl/count_seg_display.sv
// Registers the upstream 4-bit count, tallies F->0 wraps in 3-digit BCD and multiplexes the
// live count plus the tally onto a 4-digit common-anode 7-segment display.
module count_seg_display
  import seg_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  count,
  input  logic        clr,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [11:0] tally,
  output logic        ovf
);

  localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CntW-1:0] ScanLast = CntW'(SCAN_DIV - 1);

  logic [3:0]      cur_q, cur_d;
  logic [3:0]      prev_q, prev_d;
  logic [11:0]     tally_q, tally_d;
  logic            ovf_q, ovf_d;
  logic [CntW-1:0] scan_cnt_q, scan_cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [3:0]      an_q, an_d;
  logic [6:0]      seg_q, seg_d;
  logic            dp_q, dp_d;

  logic            wrap;
  logic [12:0]     tally_inc;
  logic [3:0]      digit;
  logic [6:0]      digit_seg;

  seg7_decode u_seg7_decode (
    .digit_i (digit),
    .seg_o   (digit_seg)
  );

  always_comb begin
    cur_d     = count;
    prev_d    = cur_q;
    wrap      = (prev_q == WRAP_FROM) && (cur_q == WRAP_TO);
    tally_inc = bcd3_inc(tally_q);

    tally_d = tally_q;
    ovf_d   = ovf_q;
    // Clear wins over a coincident wrap; that wrap is discarded.
    if (clr) begin
      tally_d = 12'h000;
      ovf_d   = 1'b0;
    end else if (wrap) begin
      tally_d = tally_inc[11:0];
      if (tally_inc[12]) begin
        ovf_d = 1'b1;
      end
    end

    scan_cnt_d = scan_cnt_q + CntW'(1);
    idx_d      = idx_q;
    if (scan_cnt_q == ScanLast) begin
      scan_cnt_d = '0;
      idx_d      = idx_q + 2'd1;
    end

    digit = cur_q;
    unique case (idx_q)
      2'd0: digit = cur_q;
      2'd1: digit = tally_q[3:0];
      2'd2: digit = tally_q[7:4];
      2'd3: digit = tally_q[11:8];
    endcase

    an_d  = AN_PAT[idx_q];
    seg_d = digit_seg;
    dp_d  = (idx_q == 2'd3) ? ~ovf_q : 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_q      <= 4'h0;
      prev_q     <= 4'h0;
      tally_q    <= 12'h000;
      ovf_q      <= 1'b0;
      scan_cnt_q <= '0;
      idx_q      <= 2'd0;
      an_q       <= 4'b1111;
      seg_q      <= SEG_BLANK;
      dp_q       <= 1'b1;
    end else begin
      cur_q      <= cur_d;
      prev_q     <= prev_d;
      tally_q    <= tally_d;
      ovf_q      <= ovf_d;
      scan_cnt_q <= scan_cnt_d;
      idx_q      <= idx_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
    end
  end

  assign an    = an_q;
  assign seg   = seg_q;
  assign dp    = dp_q;
  assign tally = tally_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_count_seg_display.sv
// Scoreboard bench for count_seg_display: stimulus queues expected values tagged with the
// cycle they are due, a monitor compares them against the DUT on the falling edge.
module tb_count_seg_display;

  localparam int unsigned ScanDiv = 4;
  localparam int FAn = 0, FSeg = 1, FDp = 2, FTally = 3, FOvf = 4;

  localparam logic [6:0] SegRef [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  localparam logic [3:0] AnRef [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  typedef struct {
    int          due;
    int          fld;
    logic [11:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clr = 1'b0;
  logic [3:0]  count = 4'h0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic [11:0] tally;
  logic        ovf;

  exp_t sb[$];
  exp_t keep[$];
  int   cyc = 0;
  int   rel_c = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  count_seg_display #(
    .SCAN_DIV (ScanDiv)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .count (count),
    .clr   (clr),
    .an    (an),
    .seg   (seg),
    .dp    (dp),
    .tally (tally),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int n, input int fld, input logic [11:0] v);
    exp_t e;
    e.due = cyc + n;
    e.fld = fld;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic push_reset();
    push_exp(0, FAn, 12'hF);
    push_exp(0, FSeg, 12'h7F);
    push_exp(0, FDp, 12'h1);
    push_exp(0, FTally, 12'h000);
    push_exp(0, FOvf, 12'h0);
  endtask

  // Digit index whose pattern is on the outputs after the edge that brings cyc to 'due'.
  function automatic int exp_idx(input int due);
    int k;
    k = due - rel_c;
    return ((k - 1) / int'(ScanDiv)) % 4;
  endfunction

  task automatic check_frame(input logic [3:0] cur, input logic [11:0] t, input logic ov,
                             input int len);
    int         a;
    logic [6:0] s;
    for (int n = 1; n <= len; n++) begin
      a = exp_idx(cyc + n);
      case (a)
        0:       s = SegRef[cur];
        1:       s = SegRef[t[3:0]];
        2:       s = SegRef[t[7:4]];
        default: s = SegRef[t[11:8]];
      endcase
      push_exp(n, FAn, {8'h0, AnRef[a]});
      push_exp(n, FSeg, {5'h0, s});
      push_exp(n, FDp, (a == 3) ? {11'h0, ~ov} : 12'h1);
    end
    repeat (len) tick();
  endtask

  task automatic do_wrap();
    count = 4'hF;
    tick();
    count = 4'h0;
    tick();
  endtask

  task automatic check(input exp_t e);
    logic [11:0] act;
    string       nm;
    case (e.fld)
      FAn:     begin act = {8'h0, an};    nm = "an";    end
      FSeg:    begin act = {5'h0, seg};   nm = "seg";   end
      FDp:     begin act = {11'h0, dp};   nm = "dp";    end
      FTally:  begin act = tally;         nm = "tally"; end
      default: begin act = {11'h0, ovf};  nm = "ovf";   end
    endcase
    n_tests++;
    if (act !== e.val) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, e.due, act, e.val);
    end
  endtask

  initial forever begin
    @(negedge clk);
    keep = {};
    foreach (sb[i]) begin
      if (sb[i].due == cyc) check(sb[i]);
      else keep.push_back(sb[i]);
    end
    sb = keep;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset held with random count.
    count = 4'($urandom);
    repeat (2) tick();
    for (int i = 0; i < 3; i++) begin
      count = 4'($urandom);
      push_reset();
      tick();
    end

    // Release; first edge shows digit 0 with cur_q still 0, then scan with count 7.
    count = 4'h7;
    rst   = 1'b1;
    rel_c = cyc;
    push_exp(1, FAn, 12'hE);
    push_exp(1, FSeg, 12'h40);
    push_exp(1, FTally, 12'h000);
    tick();
    check_frame(4'h7, 12'h000, 1'b0, 20);

    // Natural wrap after 0..F, then a 5->0 jump that must not count.
    for (int v = 0; v < 16; v++) begin
      count = 4'(v);
      tick();
    end
    count = 4'h0;
    push_exp(1, FTally, 12'h000);
    push_exp(2, FTally, 12'h001);
    tick();
    count = 4'h5;
    tick();
    count = 4'h0;
    push_exp(2, FTally, 12'h001);
    push_exp(3, FTally, 12'h001);
    repeat (3) tick();

    // Back-to-back F/0 toggles: one wrap per F->0.
    count = 4'hF;
    tick();
    count = 4'h0;
    push_exp(2, FTally, 12'h002);
    tick();
    count = 4'hF;
    tick();
    count = 4'h0;
    push_exp(2, FTally, 12'h003);
    repeat (3) tick();
    check_frame(4'h0, 12'h003, 1'b0, 16);

    // Clear coinciding with a wrap: wrap dropped.
    count = 4'hF;
    tick();
    count = 4'h0;
    tick();
    clr = 1'b1;
    push_exp(0, FTally, 12'h003);
    push_exp(1, FTally, 12'h000);
    push_exp(1, FOvf, 12'h0);
    tick();
    clr = 1'b0;
    push_exp(2, FTally, 12'h000);
    repeat (3) tick();

    // Preload 999 wraps, then roll over into ovf.
    repeat (999) do_wrap();
    push_exp(1, FTally, 12'h999);
    push_exp(1, FOvf, 12'h0);
    tick();
    count = 4'hF;
    tick();
    count = 4'h0;
    push_exp(2, FTally, 12'h000);
    push_exp(2, FOvf, 12'h1);
    repeat (3) tick();
    check_frame(4'h0, 12'h000, 1'b1, 16);

    // Plain clear drops the sticky flag.
    clr = 1'b1;
    push_exp(1, FOvf, 12'h0);
    push_exp(1, FTally, 12'h000);
    tick();
    clr = 1'b0;
    tick();

    // Build tally 042, then reset in the middle of digit index 2.
    repeat (42) do_wrap();
    tick();
    push_exp(0, FTally, 12'h042);
    tick();
    check_frame(4'h0, 12'h042, 1'b0, 16);
    while (((((cyc - rel_c) / int'(ScanDiv)) % 4) != 2) || (((cyc - rel_c) % int'(ScanDiv)) != 1))
      tick();
    rst = 1'b0;
    push_reset();
    tick();
    push_reset();
    tick();
    rst   = 1'b1;
    rel_c = cyc;
    push_exp(1, FAn, 12'hE);
    push_exp(1, FSeg, 12'h40);
    push_exp(1, FTally, 12'h000);
    tick();
    check_frame(4'h0, 12'h000, 1'b0, 16);

    repeat (2) tick();
    foreach (sb[i]) begin
      n_tests++;
      n_fail++;
      $display("FAIL pending check never reached: due %0d, got none, expected %0h",
               sb[i].due, sb[i].val);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
